// File: rtl/tsc_fetch_unit.sv
// Instruction-fetch stage for the TSC CPU: owns the PC, runs a req/ack handshake to
// instruction memory and holds each word for decode. Optional JMP predecode: TSC_JMP_PREDECODE_EN.
module tsc_fetch_unit #(
    parameter int PC_WIDTH   = 16,
    parameter int INST_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_cpu,
    input  logic                  cpu_enable,
    output logic                  mem_req,
    output logic [PC_WIDTH-1:0]   mem_addr,
    input  logic                  mem_ack,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [7:0]            PC_below8bit,
    output logic [CNT_WIDTH-1:0]  num_inst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } state_t;

    state_t                state;
    state_t                launch_state;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   fetch_next_pc;
    logic                  req_q;
    logic                  valid_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic [PC_WIDTH-1:0]   inst_pc_q;
    logic [CNT_WIDTH-1:0]  count_q;

    // Where the unit goes whenever nothing is in flight or held any more.
    assign launch_state = cpu_enable ? REQ : IDLE;

`ifdef TSC_JMP_PREDECODE_EN
    // An absolute JMP in the returning word steers the PC without waiting for decode.
    always_comb begin
        fetch_next_pc = pc + PC_WIDTH'(1);
        if (mem_rdata[15:12] == 4'h9) begin
            fetch_next_pc = {pc[PC_WIDTH-1:12], mem_rdata[11:0]};
        end
    end
`else
    always_comb begin
        fetch_next_pc = pc + PC_WIDTH'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_cpu) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            count_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (cpu_enable) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                // A request stays up until acked, regardless of cpu_enable.
                REQ: begin
                    if (mem_ack) begin
                        if (redirect_valid) begin
                            pc    <= redirect_pc;
                            state <= launch_state;
                            req_q <= cpu_enable;
                        end else begin
                            inst_q    <= mem_rdata;
                            inst_pc_q <= pc;
                            pc        <= fetch_next_pc;
                            state     <= HOLD;
                            req_q     <= 1'b0;
                            valid_q   <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= KILL;
                        req_q <= 1'b0;
                    end
                end
                KILL: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (mem_ack) begin
                        state <= launch_state;
                        req_q <= cpu_enable;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        count_q <= count_q + CNT_WIDTH'(1);
                    end
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (inst_ready || redirect_valid) begin
                        valid_q <= 1'b0;
                        state   <= launch_state;
                        req_q   <= cpu_enable;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = req_q;
    assign mem_addr     = pc;
    assign inst_valid   = valid_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign num_inst     = count_q;
    assign PC_below8bit = pc[7:0];

    // A request and a held instruction are mutually exclusive.
    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            assert (!(req_q && valid_q));
            assert (req_q == (state == REQ));
            assert (valid_q == (state == HOLD));
        end
    end

endmodule

// File: tb/tb_tsc_fetch_unit.sv
// Self-checking bench for tsc_fetch_unit: directed table, hand-written corner sequences
// and random stimulus against a transaction-level reference model.
module tb_tsc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_cpu = 1'b0;
    logic        cpu_enable = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [7:0]  PC_below8bit;
    logic [15:0] num_inst;

    int errors = 0;
    int checks = 0;

    tsc_fetch_unit dut (
        .clk(clk), .reset_cpu(reset_cpu), .cpu_enable(cpu_enable),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .PC_below8bit(PC_below8bit), .num_inst(num_inst)
    );

    always #5 clk = ~clk;

    // Reference model: tracks what is in flight (a live request, an abandoned one,
    // a held word) rather than an explicit state register.
    logic [15:0] m_pc, m_inst, m_ipc, m_cnt;
    logic        m_req, m_kill, m_valid;

    function automatic logic is_jmp(input logic [15:0] w);
`ifdef TSC_JMP_PREDECODE_EN
        return w[15:12] == 4'h9;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelStep(input logic rst_n, en, ack, input logic [15:0] rdata,
                             input logic ready, redir, input logic [15:0] rpc);
        logic [15:0] npc;
        logic n_req, n_kill, n_valid;
        if (!rst_n) begin
            m_pc = 16'd0; m_req = 0; m_kill = 0; m_valid = 0;
            m_inst = 16'd0; m_ipc = 16'd0; m_cnt = 16'd0;
            return;
        end
        npc = m_pc; n_req = m_req; n_kill = m_kill; n_valid = m_valid;
        if (m_valid) begin
            if (ready) m_cnt = m_cnt + 16'd1;
            if (ready || redir) n_valid = 0;
        end
        if (m_req && ack) begin
            n_req = 0;
            if (!redir) begin
                m_inst = rdata; m_ipc = m_pc; n_valid = 1;
                npc = is_jmp(rdata) ? {m_pc[15:12], rdata[11:0]} : m_pc + 16'd1;
            end
        end else if (m_req && redir) begin
            n_req = 0; n_kill = 1;
        end
        if (m_kill && ack) n_kill = 0;
        if (redir) npc = rpc;
        if (!n_req && !n_kill && !n_valid && en) n_req = 1;
        m_pc = npc; m_req = n_req; m_kill = n_kill; m_valid = n_valid;
    endtask

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkEq("model mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) checkEq("model mem_addr", 32'(mem_addr), 32'(m_pc));
        checkEq("model inst_valid", 32'(inst_valid), 32'(m_valid));
        checkEq("model inst", 32'(inst), 32'(m_inst));
        checkEq("model inst_pc", 32'(inst_pc), 32'(m_ipc));
        checkEq("model num_inst", 32'(num_inst), 32'(m_cnt));
        checkEq("model PC_below8bit", 32'(PC_below8bit), 32'(m_pc[7:0]));
    endtask

    // Drive one cycle's inputs, clock them in, then compare away from the edge.
    task automatic applyStimulus(input logic rst_n, en, ack, input logic [15:0] rdata,
                                 input logic ready, redir, input logic [15:0] rpc);
        reset_cpu = rst_n; cpu_enable = en; mem_ack = ack; mem_rdata = rdata;
        inst_ready = ready; redirect_valid = redir; redirect_pc = rpc;
        @(posedge clk);
        modelStep(rst_n, en, ack, rdata, ready, redir, rpc);
        #1;
        checkOutput();
    endtask

    typedef struct {
        logic        rst_n, en, ack;
        logic [15:0] rdata;
        logic        ready, redir;
        logic [15:0] rpc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_inst, e_ipc, e_num;
        logic [7:0]  e_pc8;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Reset, then stream three words with one wait cycle per fetch.
        vecs[0]  = '{0,1,0,16'h0000,1,0,16'h0, 0,16'h0,0,16'h0000,16'h0,16'h0,8'h0};
        vecs[1]  = '{0,1,0,16'h0000,1,0,16'h0, 0,16'h0,0,16'h0000,16'h0,16'h0,8'h0};
        vecs[2]  = '{1,1,0,16'h0000,1,0,16'h0, 1,16'h0,0,16'h0000,16'h0,16'h0,8'h0};
        vecs[3]  = '{1,1,0,16'h0000,1,0,16'h0, 1,16'h0,0,16'h0000,16'h0,16'h0,8'h0};
        vecs[4]  = '{1,1,1,16'h6000,1,0,16'h0, 0,16'h0,1,16'h6000,16'h0,16'h0,8'h1};
        vecs[5]  = '{1,1,0,16'h0000,1,0,16'h0, 1,16'h1,0,16'h6000,16'h0,16'h1,8'h1};
        vecs[6]  = '{1,1,0,16'h0000,1,0,16'h0, 1,16'h1,0,16'h6000,16'h0,16'h1,8'h1};
        vecs[7]  = '{1,1,1,16'h6101,1,0,16'h0, 0,16'h0,1,16'h6101,16'h1,16'h1,8'h2};
        vecs[8]  = '{1,1,0,16'h0000,1,0,16'h0, 1,16'h2,0,16'h6101,16'h1,16'h2,8'h2};
        vecs[9]  = '{1,1,0,16'h0000,1,0,16'h0, 1,16'h2,0,16'h6101,16'h1,16'h2,8'h2};
        vecs[10] = '{1,1,1,16'h6202,1,0,16'h0, 0,16'h0,1,16'h6202,16'h2,16'h2,8'h3};
        vecs[11] = '{1,0,0,16'h0000,1,0,16'h0, 0,16'h0,0,16'h6202,16'h2,16'h3,8'h3};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].ack, vecs[i].rdata,
                          vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            checkEq($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) checkEq($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            checkEq($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
            checkEq($sformatf("vec%0d inst", i), 32'(inst), 32'(vecs[i].e_inst));
            checkEq($sformatf("vec%0d inst_pc", i), 32'(inst_pc), 32'(vecs[i].e_ipc));
            checkEq($sformatf("vec%0d num_inst", i), 32'(num_inst), 32'(vecs[i].e_num));
            checkEq($sformatf("vec%0d pc8", i), 32'(PC_below8bit), 32'(vecs[i].e_pc8));
        end

        // Backpressure: word f01c held for 5 cycles, then accepted.
        $display("[TB] backpressure");
        applyStimulus(1,1,0,16'h0,0,0,16'h0);
        checkEq("bp req at 3", 32'(mem_addr), 32'd3);
        applyStimulus(1,1,1,16'hf01c,0,0,16'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1,1,0,16'h0,0,0,16'h0);
            checkEq("bp inst stable", 32'(inst), 32'hf01c);
            checkEq("bp no req", 32'(mem_req), 32'd0);
            checkEq("bp num held", 32'(num_inst), 32'd3);
        end
        applyStimulus(1,1,0,16'h0,1,0,16'h0);
        checkEq("bp accepted", 32'(num_inst), 32'd4);
        checkEq("bp next addr", 32'(mem_addr), 32'd4);

        // Redirect while the request at PC=4 is outstanding; late ack dropped.
        $display("[TB] redirect during request");
        applyStimulus(1,1,0,16'h0,0,1,16'd21);
        checkEq("kill no req", 32'(mem_req), 32'd0);
        applyStimulus(1,1,0,16'h0,0,0,16'h0);
        applyStimulus(1,1,0,16'h0,0,0,16'h0);
        checkEq("kill still waiting", 32'(mem_req), 32'd0);
        applyStimulus(1,1,1,16'hf41c,0,0,16'h0);
        checkEq("kill next req", 32'(mem_req), 32'd1);
        checkEq("kill next addr", 32'(mem_addr), 32'd21);
        checkEq("kill dropped", 32'(inst_valid), 32'd0);
        checkEq("kill num", 32'(num_inst), 32'd4);

        // Redirect coinciding with ack, then reset mid-request at PC=9.
        $display("[TB] reset mid-request");
        applyStimulus(1,1,1,16'h7777,0,1,16'd9);
        checkEq("redir+ack addr", 32'(mem_addr), 32'd9);
        checkEq("redir+ack no inst", 32'(inst_valid), 32'd0);
        applyStimulus(0,1,0,16'h0,0,0,16'h0);
        checkEq("rst pc", 32'(PC_below8bit), 32'd0);
        checkEq("rst num", 32'(num_inst), 32'd0);
        checkEq("rst req", 32'(mem_req), 32'd0);
        applyStimulus(1,0,1,16'h5555,0,0,16'h0);
        checkEq("late ack valid", 32'(inst_valid), 32'd0);
        checkEq("late ack inst", 32'(inst), 32'd0);
        checkEq("late ack pc", 32'(PC_below8bit), 32'd0);

        // cpu_enable dropped while the request at PC=7 is pending.
        $display("[TB] cpu_enable low");
        applyStimulus(1,1,0,16'h0,0,1,16'd7);
        checkEq("en req at 7", 32'(mem_addr), 32'd7);
        applyStimulus(1,0,0,16'h0,0,0,16'h0);
        checkEq("en req held", 32'(mem_req), 32'd1);
        applyStimulus(1,0,0,16'h0,0,0,16'h0);
        applyStimulus(1,0,1,16'h1234,0,0,16'h0);
        checkEq("en hold", 32'(inst_valid), 32'd1);
        checkEq("en inst_pc", 32'(inst_pc), 32'd7);
        applyStimulus(1,0,0,16'h0,1,0,16'h0);
        checkEq("en counted", 32'(num_inst), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1,0,0,16'h0,0,0,16'h0);
            checkEq("en idle no req", 32'(mem_req), 32'd0);
        end

        // JMP word at PC=16.
        $display("[TB] predecode");
        applyStimulus(1,1,0,16'h0,0,1,16'd16);
        applyStimulus(1,1,1,16'h9015,0,0,16'h0);
        checkEq("jmp inst_pc", 32'(inst_pc), 32'd16);
        applyStimulus(1,1,0,16'h0,1,0,16'h0);
`ifdef TSC_JMP_PREDECODE_EN
        checkEq("jmp next addr", 32'(mem_addr), 32'd21);
`else
        checkEq("jmp next addr", 32'(mem_addr), 32'd17);
`endif
        checkEq("jmp counted", 32'(num_inst), 32'd2);

        // Random traffic against the model.
        $display("[TB] random");
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(3) == 0) w[15:12] = 4'h9;
            applyStimulus($urandom_range(63) != 0, $urandom_range(4) != 0,
                          $urandom_range(2) == 0, w, $urandom_range(1) == 1,
                          $urandom_range(7) == 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tsc_fetch_unit.md
Name: tsc_fetch_unit

Overview:
- Parametrised instruction-fetch stage for the TSC CPU.
- Replaces the fixed 8-bit, always-increment PC of the current core.
- Owns the PC and runs a req/ack handshake to instruction memory, with variable memory latency.
- Holds each fetched instruction until decode accepts it, accepts redirects (jump/branch) at any time, and counts retired fetches for simulation.

Parameters:
- PC_WIDTH, 16, width of PC and redirect target.
- INST_WIDTH, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 16, width of num_inst counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_cpu  input  1  synchronous, active-low reset; sampled on rising clk.
- cpu_enable  input  1  when 0, no new memory request is issued; an outstanding request still completes.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  PC_WIDTH  fetch address; equals PC while mem_req=1.
- mem_ack  input  1  memory returns mem_rdata this cycle; ignored unless a request is outstanding.
- mem_rdata  input  INST_WIDTH  instruction word, valid when mem_ack=1.
- inst_valid  output  1  inst holds an unconsumed instruction.
- inst  output  INST_WIDTH  fetched instruction.
- inst_pc  output  PC_WIDTH  address inst was fetched from.
- inst_ready  input  1  decode accepts inst this cycle when inst_valid=1.
- redirect_valid  input  1  load redirect_pc as next fetch address.
- redirect_pc  input  PC_WIDTH  redirect target.
- PC_below8bit  output  8  PC[7:0], for the LED output logic.
- num_inst  output  CNT_WIDTH  instructions accepted by decode since reset; simulation only.

Behaviour:
- Reset (reset_cpu=0 at rising clk) forces:
  - state=IDLE, PC=RESET_PC, mem_req=0, inst_valid=0, inst=0, inst_pc=0, num_inst=0.
  - The reset value of every other output follows from these.
  - A reset mid-request abandons it; a late mem_ack after reset is ignored in IDLE.
- States: IDLE, REQ, HOLD, KILL.
- IDLE:
  - mem_req=0.
  - If cpu_enable=1, go to REQ next cycle.
  - Redirect in IDLE loads PC only.
- REQ:
  - mem_req=1, mem_addr=PC.
  - mem_ack=1 and no redirect: latch inst=mem_rdata, inst_pc=PC; PC<=PC+1 (wraps mod 2^PC_WIDTH); go to HOLD.
  - Redirect without ack: PC<=redirect_pc; go to KILL.
  - Redirect with ack in the same cycle: data discarded, PC<=redirect_pc, go to IDLE if cpu_enable=0, else REQ.
- KILL:
  - mem_req=0; waits for the ack of the abandoned request.
  - On mem_ack, discard data and go to REQ (or IDLE if cpu_enable=0).
  - A redirect in KILL updates PC only.
- HOLD:
  - inst_valid=1; inst/inst_pc stable.
  - inst_ready=1: num_inst+1 (wraps); go to REQ if cpu_enable=1, else IDLE.
  - Redirect in HOLD: inst_valid drops next cycle, held instruction is not counted, PC<=redirect_pc, go to REQ/IDLE per cpu_enable.
  - Redirect with inst_ready in the same cycle: the instruction is counted as accepted and the redirect wins for PC.
- Latency:
  - Zero-wait memory (ack in the first REQ cycle) gives inst_valid 1 cycle after mem_req rises.
  - Sustained throughput is 1 instruction per 2 cycles.
- mem_req is never asserted while inst_valid=1. At most one request is outstanding.
- cpu_enable=0 never drops an asserted mem_req before ack.

Optional Feature:
- Macro: TSC_JMP_PREDECODE_EN.
- Defined:
  - On the REQ ack, if mem_rdata[15:12]==4'h9 (JMP) and no external redirect, set PC<={PC[15:12], mem_rdata[11:0]} instead of PC+1.
  - The instruction is still presented in HOLD and counted.
- Not defined: PC always goes to PC+1 after a fetch, and redirects come only from redirect_valid.

Test Plan:
- Reset and stream:
  - Release reset with cpu_enable=1, ack the cycle after each mem_req, inst_ready=1, words 16'h6000,16'h6101,16'h6202.
  - Expect mem_addr 0,1,2; inst_pc 0,1,2; num_inst=3; PC_below8bit=3.
- Backpressure:
  - Hold inst_ready=0 for 5 cycles in HOLD.
  - Expect inst stable at 16'hf01c, mem_req=0 throughout, num_inst unchanged; accepted on release.
- Redirect during outstanding request:
  - At PC=4, assert redirect_valid, redirect_pc=21; ack 3 cycles later with 16'hf41c.
  - Expect KILL, data dropped, next mem_addr=21, num_inst unchanged.
- Reset mid-operation:
  - Pull reset_cpu=0 in REQ at PC=9, then raise mem_ack.
  - Expect PC=0, inst_valid=0, num_inst=0, ack ignored.
- cpu_enable low:
  - Deassert cpu_enable while in REQ at PC=7; ack after 2 cycles.
  - Expect the fetch completes to HOLD, and after acceptance the unit goes to IDLE with no new mem_req.
- Predecode (TSC_JMP_PREDECODE_EN):
  - Fetch 16'h9015 at PC=16.
  - Expect next mem_addr=21 without any redirect_valid.
  - With the macro undefined, expect next mem_addr=17.
